// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT sequencing and
// the IF/ID output register with valid/ready handshake.
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] END_PC   = 8'h4C
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [7:0]  out_pc,
    output logic [7:0]  out_pc_plus4,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] pc;
    logic       xfer;
    logic       load;
    logic       at_end;
    logic       unused_rpc_lo;

    assign xfer   = out_valid && out_ready;
    assign load   = (state == RUN) && (!out_valid || out_ready)
                    && !redirect_valid;
    assign at_end = (pc[7:2] == END_PC[7:2]);

    assign imem_addr     = pc;
    assign halted        = (state == HALT);
    assign unused_rpc_lo = ^redirect_pc[1:0];

    // Redirect outranks everything, including halt detection.
    always_comb begin
        state_nx = state;
        priority case (1'b1)
            redirect_valid:  state_nx = RUN;
            state == IDLE:   state_nx = RUN;
            load && at_end:  state_nx = HALT;
            default:         state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= {RESET_PC[7:2], 2'b00};
            out_valid    <= 1'b0;
            out_instr    <= 32'h0;
            out_pc       <= 8'h00;
            out_pc_plus4 <= 8'h00;
            fetch_count  <= 16'h0;
        end else begin
            if (xfer && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (redirect_valid) begin
                pc        <= {redirect_pc[7:2], 2'b00};
                out_valid <= 1'b0;
            end else if (load) begin
                out_instr    <= imem_instr;
                out_pc       <= pc;
                out_pc_plus4 <= pc + 8'd4;
                out_valid    <= 1'b1;
                pc           <= pc + 8'd4;
            end else if (state != RUN && xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: three instances cover the default
// program, an early halt and a wrapping PC range.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    function automatic logic [31:0] mem(input logic [7:0] a);
        return {24'hC0DE00, a};
    endfunction

    logic        a_rst, a_rv, a_rdy, a_ov, a_h;
    logic [7:0]  a_addr, a_rpc, a_pc, a_pc4;
    logic [31:0] a_in, a_oi;
    logic [15:0] a_cnt;

    logic        b_rst, b_rv, b_rdy, b_ov, b_h;
    logic [7:0]  b_addr, b_rpc, b_pc, b_pc4;
    logic [31:0] b_in, b_oi;
    logic [15:0] b_cnt;

    logic        c_rst, c_rv, c_rdy, c_ov, c_h;
    logic [7:0]  c_addr, c_rpc, c_pc, c_pc4;
    logic [31:0] c_in, c_oi;
    logic [15:0] c_cnt;

    assign a_in = mem(a_addr);
    assign b_in = mem(b_addr);
    assign c_in = mem(c_addr);

    fetch_stage u_a (
        .clk(clk), .rst(a_rst), .imem_addr(a_addr),
        .imem_instr(a_in), .redirect_valid(a_rv),
        .redirect_pc(a_rpc), .out_valid(a_ov),
        .out_ready(a_rdy), .out_instr(a_oi), .out_pc(a_pc),
        .out_pc_plus4(a_pc4), .halted(a_h),
        .fetch_count(a_cnt)
    );

    fetch_stage #(.RESET_PC(8'h00), .END_PC(8'h10)) u_b (
        .clk(clk), .rst(b_rst), .imem_addr(b_addr),
        .imem_instr(b_in), .redirect_valid(b_rv),
        .redirect_pc(b_rpc), .out_valid(b_ov),
        .out_ready(b_rdy), .out_instr(b_oi), .out_pc(b_pc),
        .out_pc_plus4(b_pc4), .halted(b_h),
        .fetch_count(b_cnt)
    );

    fetch_stage #(.RESET_PC(8'hF8), .END_PC(8'h04)) u_c (
        .clk(clk), .rst(c_rst), .imem_addr(c_addr),
        .imem_instr(c_in), .redirect_valid(c_rv),
        .redirect_pc(c_rpc), .out_valid(c_ov),
        .out_ready(c_rdy), .out_instr(c_oi), .out_pc(c_pc),
        .out_pc_plus4(c_pc4), .halted(c_h),
        .fetch_count(c_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1; a_rv = 0; a_rpc = 0; a_rdy = 1;
        b_rst = 1; b_rv = 0; b_rpc = 0; b_rdy = 1;
        c_rst = 1; c_rv = 0; c_rpc = 0; c_rdy = 1;
        step();
        chk("a_rst_valid", 32'(a_ov), 32'h0);
        chk("a_rst_addr", 32'(a_addr), 32'h00);
        chk("a_rst_cnt", 32'(a_cnt), 32'h0);
        chk("a_rst_halt", 32'(a_h), 32'h0);
        chk("c_rst_addr", 32'(c_addr), 32'hF8);

        a_rst = 0;
        step();
        chk("a_idle_valid", 32'(a_ov), 32'h0);
        step();
        chk("a_pc0", 32'(a_pc), 32'h00);
        chk("a_pc0_p4", 32'(a_pc4), 32'h04);
        chk("a_pc0_valid", 32'(a_ov), 32'h1);
        step();
        chk("a_pc1", 32'(a_pc), 32'h04);
        chk("a_pc1_p4", 32'(a_pc4), 32'h08);
        step();
        chk("a_pc2", 32'(a_pc), 32'h08);
        chk("a_pc2_p4", 32'(a_pc4), 32'h0C);
        chk("a_pc2_cnt", 32'(a_cnt), 32'd2);

        a_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a_bp_pc", 32'(a_pc), 32'h08);
            chk("a_bp_instr", a_oi, mem(8'h08));
            chk("a_bp_addr", 32'(a_addr), 32'h0C);
            chk("a_bp_cnt", 32'(a_cnt), 32'd2);
        end
        a_rdy = 1;
        step();
        chk("a_rel_pc", 32'(a_pc), 32'h0C);
        chk("a_rel_cnt", 32'(a_cnt), 32'd3);

        a_rdy = 0; a_rv = 1; a_rpc = 8'h2B;
        step();
        chk("a_fl_valid", 32'(a_ov), 32'h0);
        chk("a_fl_addr", 32'(a_addr), 32'h28);
        chk("a_fl_cnt", 32'(a_cnt), 32'd3);
        a_rv = 0; a_rdy = 1;
        step();
        chk("a_fl_pc", 32'(a_pc), 32'h28);
        chk("a_fl_instr", a_oi, 32'hC0DE0028);
        step();
        step();
        chk("a_pre_cnt", 32'(a_cnt), 32'd5);
        a_rdy = 0;
        step();
        chk("a_st_pc", 32'(a_pc), 32'h30);
        a_rst = 1; a_rdy = 1; a_rv = 1; a_rpc = 8'h80;
        step();
        chk("a_mr_valid", 32'(a_ov), 32'h0);
        chk("a_mr_instr", a_oi, 32'h0);
        chk("a_mr_pc", 32'(a_pc), 32'h0);
        chk("a_mr_p4", 32'(a_pc4), 32'h0);
        chk("a_mr_addr", 32'(a_addr), 32'h00);
        chk("a_mr_cnt", 32'(a_cnt), 32'h0);
        a_rv = 0;

        b_rst = 0;
        repeat (5) step();
        chk("b_pre_pc", 32'(b_pc), 32'h0C);
        chk("b_pre_halt", 32'(b_h), 32'h0);
        step();
        chk("b_end_pc", 32'(b_pc), 32'h10);
        chk("b_end_valid", 32'(b_ov), 32'h1);
        chk("b_end_halt", 32'(b_h), 32'h1);
        chk("b_end_cnt", 32'(b_cnt), 32'd4);
        step();
        chk("b_h_valid", 32'(b_ov), 32'h0);
        chk("b_h_cnt", 32'(b_cnt), 32'd5);
        step();
        chk("b_h2_valid", 32'(b_ov), 32'h0);
        chk("b_h2_halt", 32'(b_h), 32'h1);
        chk("b_h2_addr", 32'(b_addr), 32'h14);
        b_rv = 1; b_rpc = 8'h00;
        step();
        chk("b_rd_halt", 32'(b_h), 32'h0);
        chk("b_rd_valid", 32'(b_ov), 32'h0);
        b_rv = 0;
        step();
        chk("b_rd_pc", 32'(b_pc), 32'h00);
        chk("b_rd_ov", 32'(b_ov), 32'h1);
        b_rv = 1; b_rpc = 8'h40;
        step();
        chk("b_rx_cnt", 32'(b_cnt), 32'd6);
        chk("b_rx_valid", 32'(b_ov), 32'h0);
        chk("b_rx_addr", 32'(b_addr), 32'h40);
        b_rv = 0;

        c_rst = 0;
        step();
        step();
        chk("c_pc0", 32'(c_pc), 32'hF8);
        step();
        chk("c_pc1", 32'(c_pc), 32'hFC);
        chk("c_pc1_p4", 32'(c_pc4), 32'h00);
        step();
        chk("c_pc2", 32'(c_pc), 32'h00);
        step();
        chk("c_pc3", 32'(c_pc), 32'h04);
        chk("c_pc3_halt", 32'(c_h), 32'h1);
        step();
        chk("c_end_valid", 32'(c_ov), 32'h0);
        chk("c_end_cnt", 32'(c_cnt), 32'd4);
        chk("c_end_halt", 32'(c_h), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 8'h00: first fetch address after reset; bits [1:0] are ignored.
REQ-002 Parameter END_PC, 8'h4C: address of the last instruction to deliver before halting; bits [1:0] are ignored.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  8  fetch address driven to instruction memory; always equals the PC register.
REQ-006 imem_instr  input  32  combinational instruction returned for imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  8  redirect target; bits [1:0] are forced to 0.
REQ-009 out_valid  output  1  IF/ID register holds a valid instruction.
REQ-010 out_ready  input  1  downstream decode accepts the IF/ID contents this cycle.
REQ-011 out_instr  output  32  registered instruction.
REQ-012 out_pc  output  8  address of out_instr.
REQ-013 out_pc_plus4  output  8  out_pc+4, modulo 256.
REQ-014 halted  output  1  high while the FSM is in HALT.
REQ-015 fetch_count  output  16  number of accepted transfers (out_valid && out_ready), saturating.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-017 IDLE SHALL go to RUN after exactly one cycle, unconditionally.
REQ-018 "load" SHALL mean: state==RUN and (!out_valid || out_ready) and !redirect_valid.
REQ-019 On load: out_instr<=imem_instr; out_pc<=pc; out_pc_plus4<=pc+4; out_valid<=1; pc<=pc+4 (8-bit wrap, 8'hFC -> 8'h00).
REQ-020 In RUN with out_valid=1 and out_ready=0, pc and all out_* SHALL hold, and imem_addr SHALL stay stable.
REQ-021 In IDLE or HALT: out_valid && out_ready SHALL clear out_valid; pc SHALL not change; no load SHALL occur.
REQ-022 When a load has pc[7:2]==END_PC[7:2], the state SHALL go to HALT on the same edge, and halted=1 from the next cycle.
REQ-023 redirect_valid=1 in any state SHALL, on that edge: set pc to {redirect_pc[7:2],2'b00}; set out_valid to 0, discarding any held instruction regardless of out_ready; and set the state to RUN.
REQ-024 A redirect SHALL take priority over load, hold and halt detection in the same cycle.
REQ-025 A redirect arriving while out_valid && out_ready is high SHALL still count that cycle's transfer in fetch_count.
REQ-026 fetch_count SHALL increment on every cycle with out_valid && out_ready, and SHALL saturate at 16'hFFFF.
REQ-027 Latency: an instruction at PC p loaded at edge N SHALL appear on out_* from N+1 and remain until accepted or flushed.

Reset
REQ-028 rst=1 at an edge SHALL set: state=IDLE; pc={RESET_PC[7:2],2'b00}; out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=0; halted=0; fetch_count=0.
REQ-029 rst SHALL dominate redirect_valid and out_ready.
REQ-030 Reset asserted mid-stall or mid-halt SHALL discard the held instruction with no transfer counted.

Verification
REQ-031 Reset, out_ready=1: out_valid=0 for the first cycle; then out_pc = 00, 04, 08 on consecutive cycles; out_pc_plus4 = 04, 08, 0C.
REQ-032 Backpressure: with out_pc=08 held, out_ready=0 for 3 cycles -> out_*, imem_addr=0C and fetch_count all stable; release -> out_pc=0C on the next cycle.
REQ-033 Flush: redirect_pc=8'h2B while stalled -> next cycle out_valid=0, imem_addr=28; the cycle after, out_pc=28, out_instr=mem[10].
REQ-034 Halt: END_PC=8'h10 -> out_pc=10 is delivered, halted=1, no further out_valid; then redirect to 00 -> halted=0 and out_pc=00 is delivered.
REQ-035 Wrap: RESET_PC=8'hF8, END_PC=8'h04 -> out_pc sequence F8, FC, 00, 04, then HALT; fetch_count=4.
REQ-036 Reset during a stall with fetch_count=5 -> next cycle: all outputs 0, imem_addr=RESET_PC, fetch_count=0.
